intersection_phase_ctrl: RTL

//   Phase sequencer for a two-road intersection: main road (NS) and side road (EW).

---
 rtl/intersection_phase_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/intersection_phase_ctrl.sv
// Two-road intersection phase sequencer: rests in NS green, serves EW on latched
// car or pedestrian requests, with yellow and all-red clearance between roads.
module intersection_phase_ctrl #(
    parameter int CW       = 5,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tick_i,
    input  logic          ew_req_i,
    input  logic          ped_req_i,
    output logic          ped_ack_o,
    output logic          ped_walk_o,
    output logic          ns_red_o,
    output logic          ns_yellow_o,
    output logic          ns_green_o,
    output logic          ew_red_o,
    output logic          ew_yellow_o,
    output logic          ew_green_o,
    output logic [2:0]    phase_o,
    output logic [CW-1:0] cnt_out_o
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR_A = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR_B = 3'd5
    } phase_e;

    localparam logic [CW-1:0] GREEN_D  = CW'(GREEN_T);
    localparam logic [CW-1:0] YELLOW_D = CW'(YELLOW_T);
    localparam logic [CW-1:0] ALLRED_D = CW'(ALLRED_T);
    localparam logic [CW-1:0] ONE      = CW'(1);

    phase_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ew_pend_q, ew_pend_d;
    logic          ped_pend_q, ped_pend_d;
    logic          ped_serve_q, ped_serve_d;
    logic          ped_ack_q, ped_ack_d;

    logic expire;
    logic enter_ewg;
    logic leave_ewg;

    assign expire    = tick_i && (cnt_q == ONE);
    assign enter_ewg = (state_q == AR_A) && expire;
    assign leave_ewg = (state_q == EW_G) && expire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= NS_G;
            cnt_q       <= GREEN_D;
            ew_pend_q   <= 1'b0;
            ped_pend_q  <= 1'b0;
            ped_serve_q <= 1'b0;
            ped_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ew_pend_q   <= ew_pend_d;
            ped_pend_q  <= ped_pend_d;
            ped_serve_q <= ped_serve_d;
            ped_ack_q   <= ped_ack_d;
        end
    end

    // Phase sequencing and countdown; each phase lasts exactly its duration in ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick_i && cnt_q > ONE) begin
            cnt_d = cnt_q - ONE;
        end
        case (state_q)
            NS_G: begin
                if (expire) begin
                    if (ew_pend_q || ped_pend_q) begin
                        state_d = NS_Y;
                        cnt_d   = YELLOW_D;
                    end else begin
                        cnt_d   = GREEN_D;
                    end
                end
            end
            NS_Y: begin
                if (expire) begin
                    state_d = AR_A;
                    cnt_d   = ALLRED_D;
                end
            end
            AR_A: begin
                if (expire) begin
                    state_d = EW_G;
                    cnt_d   = GREEN_D;
                end
            end
            EW_G: begin
                if (expire) begin
                    state_d = EW_Y;
                    cnt_d   = YELLOW_D;
                end
            end
            EW_Y: begin
                if (expire) begin
                    state_d = AR_B;
                    cnt_d   = ALLRED_D;
                end
            end
            AR_B: begin
                if (expire) begin
                    state_d = NS_G;
                    cnt_d   = GREEN_D;
                end
            end
            default: begin
                // Corrupted encoding recovers through a full all-red clearance.
                state_d = AR_B;
                cnt_d   = ALLRED_D;
            end
        endcase
    end

    // Request latches: a request in the clearing cycle survives the clear.
    always_comb begin
        ew_pend_d   = ew_req_i  || (ew_pend_q  && !enter_ewg);
        ped_pend_d  = ped_req_i || (ped_pend_q && !enter_ewg);
        ped_serve_d = ped_serve_q;
        if (enter_ewg) begin
            ped_serve_d = ped_pend_q;
        end else if (leave_ewg) begin
            ped_serve_d = 1'b0;
        end
        ped_ack_d = enter_ewg && ped_pend_q;
    end

    // Lamps decode from registered state only; unknown codes show red both ways.
    always_comb begin
        ns_red_o    = 1'b1;
        ns_yellow_o = 1'b0;
        ns_green_o  = 1'b0;
        ew_red_o    = 1'b1;
        ew_yellow_o = 1'b0;
        ew_green_o  = 1'b0;
        case (state_q)
            NS_G: begin
                ns_red_o   = 1'b0;
                ns_green_o = 1'b1;
            end
            NS_Y: begin
                ns_red_o    = 1'b0;
                ns_yellow_o = 1'b1;
            end
            EW_G: begin
                ew_red_o   = 1'b0;
                ew_green_o = 1'b1;
            end
            EW_Y: begin
                ew_red_o    = 1'b0;
                ew_yellow_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign phase_o    = state_q;
    assign cnt_out_o  = cnt_q;
    assign ped_walk_o = ped_serve_q && (state_q == EW_G);
    assign ped_ack_o  = ped_ack_q;

endmodule
